// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, status flags and FSM state.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHR = 3'b110,
    ALU_SHL = 3'b111
  } op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } flags_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational arithmetic/logic slice; shift opcodes produce zero here.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  always_comb begin
    sub        = (op_i == ALU_SUB);
    b_eff      = sub ? ~b_i : b_i;
    sum        = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    res_o      = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        res_o      = sum[WIDTH-1:0];
        // SUB reports borrow, i.e. the inverted adder carry-out
        carry_o    = sum[WIDTH] ^ sub;
        overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_NOT: res_o = ~a_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic ops, iterative one-bit-per-cycle
// shifts, and a registered result/flag stage behind a valid/ready port.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int unsigned      CW      = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_B = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] res_q, res_d;
  flags_t           flags_q, flags_d;

  op_e              op_s;
  logic             accept, is_shift, shl;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] core_res, sh1, sh_next;
  logic             core_c, core_v, out1, sh_out;
  logic             wr, wr_c, wr_v;
  logic [WIDTH-1:0] wr_res;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i        (a),
    .b_i        (b),
    .op_i       (op_s),
    .res_o      (core_res),
    .carry_o    (core_c),
    .overflow_o (core_v)
  );

  assign in_ready = (state_q == ST_IDLE) && (!ov_q || out_ready);
  assign out_valid = ov_q;
  assign result    = res_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;
  assign overflow  = flags_q.overflow;

  always_comb begin
    op_s     = op_e'(op);
    accept   = in_valid && in_ready;
    is_shift = (op_s == ALU_SHR) || (op_s == ALU_SHL);
    shl      = (op_s == ALU_SHL);
    k        = (b >= WIDTH_B) ? WIDTH_C : b[CW-1:0];
    sh1      = shl ? (a << 1) : (a >> 1);
    out1     = shl ? a[WIDTH-1] : a[0];
    sh_next  = dir_q ? (sh_q << 1) : (sh_q >> 1);
    sh_out   = dir_q ? sh_q[WIDTH-1] : sh_q[0];

    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    wr      = 1'b0;
    wr_res  = '0;
    wr_c    = 1'b0;
    wr_v    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_shift) begin
            wr     = 1'b1;
            wr_res = core_res;
            wr_c   = core_c;
            wr_v   = core_v;
          end else if (k == '0) begin
            wr     = 1'b1;
            wr_res = a;
          end else if (k == CW'(1)) begin
            wr     = 1'b1;
            wr_res = sh1;
            wr_c   = out1;
          end else begin
            // First bit moves on the accept edge so a k-bit shift completes k cycles later
            sh_d    = sh1;
            cnt_d   = k - CW'(1);
            dir_d   = shl;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          wr      = 1'b1;
          wr_res  = sh_next;
          wr_c    = sh_out;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ov_d    = ov_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (wr) begin
      ov_d             = 1'b1;
      res_d            = wr_res;
      flags_d.carry    = wr_c;
      flags_d.zero     = (wr_res == '0);
      flags_d.negative = wr_res[WIDTH-1];
      flags_d.overflow = wr_v;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases, backpressure,
// reset mid-shift, then random ops against an arithmetic reference model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       out_valid, out_ready;
  logic [7:0] result;
  logic       carry, zero, negative, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int r;
    int c;
    int z;
    int n;
    int v;
    int lat;
  } exp_t;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int ua, input int ub, input int o);
    exp_t e;
    int sa, sb, s, k;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    k  = (ub > 8) ? 8 : ub;
    e.r = 0; e.c = 0; e.v = 0;
    case (o)
      0: begin
        e.r = (ua + ub) % 256;
        e.c = (ua + ub) / 256;
        s   = sa + sb;
        e.v = (s > 127 || s < -128) ? 1 : 0;
      end
      1: begin
        e.r = (ua - ub + 256) % 256;
        e.c = (ua < ub) ? 1 : 0;
        s   = sa - sb;
        e.v = (s > 127 || s < -128) ? 1 : 0;
      end
      2: e.r = ua & ub;
      3: e.r = ua | ub;
      4: e.r = ua ^ ub;
      5: e.r = 255 - ua;
      6: begin
        e.r = ua >> k;
        e.c = (k == 0) ? 0 : ((ua >> (k - 1)) & 1);
      end
      default: begin
        e.r = (ua << k) % 256;
        e.c = (k == 0) ? 0 : ((ua >> (8 - k)) & 1);
      end
    endcase
    e.z   = (e.r == 0) ? 1 : 0;
    e.n   = (e.r >= 128) ? 1 : 0;
    e.lat = (o >= 6 && k > 0) ? k : 1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".result"}, 32'(result), e.r);
    chk({tag, ".carry"}, 32'(carry), e.c);
    chk({tag, ".zero"}, 32'(zero), e.z);
    chk({tag, ".neg"}, 32'(negative), e.n);
    chk({tag, ".ovf"}, 32'(overflow), e.v);
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (!in_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk({tag, ".ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Issues one op at a negedge, then measures latency and checks the result.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] top,
                        input string tag);
    exp_t e;
    int   lat;
    e = model(int'(ta), int'(tb_v), int'(top));
    wait_ready(tag);
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (out_valid) lat = c;
      else chk({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
    end
    chk({tag, ".latency"}, lat, e.lat);
    chk_out(tag, e);
  endtask

  initial begin
    exp_t e;
    int   seen;
    logic [7:0] ra, rb;
    logic [2:0] rop;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk_out("reset", '{r: 0, c: 0, z: 0, n: 0, v: 0, lat: 0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'hFF, 8'h01, 3'd0, "add_ff_01");
    run_op(8'h05, 8'h07, 3'd1, "sub_05_07");
    run_op(8'h80, 8'h01, 3'd1, "sub_80_01");
    run_op(8'hA1, 8'h03, 3'd7, "shl_a1_3");
    run_op(8'h81, 8'h09, 3'd6, "shr_81_9");
    run_op(8'h3C, 8'hFF, 3'd5, "not_3c");
    run_op(8'h5A, 8'h5A, 3'd4, "xor_5a");
    run_op(8'h96, 8'h00, 3'd6, "shr_k0");
    run_op(8'h81, 8'h01, 3'd7, "shl_k1");
    run_op(8'hC3, 8'h08, 3'd7, "shl_k8");

    // Backpressure: hold result for 4 cycles, then accept next op on release edge
    wait_ready("bp");
    e = model(8'h7F, 8'h01, 0);
    a = 8'h7F; b = 8'h01; op = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk_out("bp.hold", e);
    end
    out_ready = 1'b1;
    a = 8'h05; b = 8'h07; op = 3'd1; in_valid = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp.next_valid", 32'(out_valid), 32'd1);
    chk_out("bp.next", model(8'h05, 8'h07, 1));

    // Reset in the middle of a shift
    wait_ready("rst");
    a = 8'hF0; b = 8'h06; op = 3'd6; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk_out("rst", '{r: 0, c: 0, z: 0, n: 0, v: 0, lat: 0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("rst.no_result", seen, 0);
    run_op(8'h02, 8'h03, 3'd0, "post_rst_add");

    for (int i = 0; i < 80; i++) begin
      ra  = 8'($urandom);
      rop = 3'($urandom);
      rb  = (rop >= 3'd6 && $urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10))
                                                       : 8'($urandom);
      run_op(ra, rb, rop, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
